dct_blk_seq: RTL and testbench
==============================

DCT_BLK_SEQ -- requirements
Module: dct_blk_seq

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning pixel sample width.
REQ-002 SHALL have parameter OUT_W, default 12, meaning coefficient width returned by the DCT core.
REQ-003 SHALL have parameter N, default 8, meaning block dimension; N*N samples per block; N a power of two, 4..16.
REQ-004 SHALL have parameter GAP, default 83, meaning idle cycles inserted after each block burst; 0 allowed.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port RST  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port s_valid  input  1  upstream sample valid.
REQ-008 SHALL have port s_data  input  IN_W  upstream sample, raster order within a block.
REQ-009 SHALL have port s_ready  output  1  sample accepted on a cycle when s_valid and s_ready are both 1.
REQ-010 SHALL have port xin  output  IN_W  sample stream to the DCT core.
REQ-011 SHALL have port dct_in  input  OUT_W  coefficient from the DCT core.
REQ-012 SHALL have port core_rdy  input  1  DCT core output-valid (core rdy_out).
REQ-013 SHALL have port m_valid, m_data[OUT_W], m_row[log2 N], m_col[log2 N], m_sob, m_eob, all outputs, meaning the tagged coefficient stream.
REQ-014 SHALL have ports in_blk_cnt[16] and out_blk_cnt[16], outputs: blocks sent to the core and blocks received from it.

Function
REQ-015 SHALL hold two banks of N*N IN_W-bit words (ping-pong): one filled by the upstream, one drained to xin.
REQ-016 Fill: s_ready=1 iff the current write bank is not full; on accepting sample N*N-1 the write bank SHALL be marked full and the write pointer SHALL switch to the other bank.
REQ-017 Drain FSM SHALL have states IDLE, BURST, GAP.
REQ-018 IDLE -> BURST when the read bank is full; otherwise stay in IDLE.
REQ-019 BURST SHALL last exactly N*N consecutive cycles; xin SHALL carry samples 0..N*N-1 of the read bank, in order and without gaps, starting the cycle after IDLE exits; sample k SHALL come from entry k.
REQ-020 On the last BURST cycle: read bank SHALL be marked empty; read pointer SHALL toggle; in_blk_cnt SHALL increment (wrap at 2^16); go to GAP if GAP>0, else IDLE.
REQ-021 GAP SHALL last exactly GAP cycles, then go to IDLE.
REQ-022 xin SHALL be 0 in every cycle outside BURST.
REQ-023 If a fill completes in the same cycle a drain empties the other bank, both SHALL take effect; s_ready SHALL be 1 the next cycle.
REQ-024 With both banks full, s_ready SHALL be 0; no sample may be lost or overwritten.
REQ-025 Output side: m_valid and m_data SHALL be core_rdy and dct_in registered one cycle.
REQ-026 A position counter SHALL advance once per cycle with m_valid=1; m_col SHALL count 0..N-1 and m_row SHALL advance when m_col wraps, both wrapping to 0 after (N-1,N-1).
REQ-027 m_sob=1 iff m_valid and row=col=0; m_eob=1 iff m_valid and row=col=N-1; m_row/m_col SHALL hold when m_valid=0.
REQ-028 out_blk_cnt SHALL increment on every m_eob (wrap at 2^16).
REQ-029 Input and output sides are independent; core latency SHALL NOT be assumed.

Reset
REQ-030 RST low SHALL asynchronously force: FSM=IDLE, both banks empty, pointers 0, xin=0, s_ready=1, m_valid=0, m_data=0, m_row=m_col=0, m_sob=m_eob=0, both block counters 0; bank contents need not clear.
REQ-031 Reset asserted mid-BURST or mid-fill SHALL discard the partial block; after release the first accepted sample is sample 0 of a new block.

Verification
REQ-032 Defaults, 64 samples of 8'h03 streamed continuously -> xin=3 for exactly 64 consecutive cycles, then 0 for 83 cycles; in_blk_cnt=1.
REQ-033 Upstream always valid, 3 blocks (values 0..63 + 64*b), GAP=0 -> 192 consecutive xin samples, correct order, no idle cycle between blocks; s_ready drops while both banks are full.
REQ-034 core_rdy high 64 cycles, dct_in=cycle index -> m_data delayed 1 cycle; m_sob on (0,0); m_eob on (7,7); out_blk_cnt=1.
REQ-035 core_rdy toggled 1010... for 128 cycles -> position advances only on valid cycles; exactly one m_eob; row/col hold on idle cycles.
REQ-036 RST pulsed low at BURST sample 20 -> xin=0 and s_ready=1 immediately; the next block's burst starts from its own sample 0.
REQ-037 N=4, GAP=2 -> 16-sample bursts separated by exactly 2 zero cycles; m_eob at (3,3).

Source files
------------

// File: rtl/dct_blk_seq.sv
// Ping-pong block sequencer feeding a DCT core and tagging its coefficient
// stream with block position, start/end markers and block counters.
module dct_blk_seq #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12,
  parameter int N     = 8,
  parameter int GAP   = 83
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   s_valid,
  input  logic [IN_W-1:0]        s_data,
  output logic                   s_ready,
  output logic [IN_W-1:0]        xin,
  input  logic [OUT_W-1:0]       dct_in,
  input  logic                   core_rdy,
  output logic                   m_valid,
  output logic [OUT_W-1:0]       m_data,
  output logic [$clog2(N)-1:0]   m_row,
  output logic [$clog2(N)-1:0]   m_col,
  output logic                   m_sob,
  output logic                   m_eob,
  output logic [15:0]            in_blk_cnt,
  output logic [15:0]            out_blk_cnt
);

  localparam int DEPTH    = N * N;
  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = $clog2(N);
  localparam int GW       = (GAP > 2) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [IN_W-1:0] mem [2][DEPTH];

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic          wr_sel;
  logic          rd_sel;
  logic          rd_sel_n;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          acc;
  logic          fill_done;
  logic          drain_done;
  logic          gap_done;

  assign s_ready    = !full[wr_sel];
  assign acc        = s_valid && s_ready;
  assign fill_done  = acc && (wr_idx == IDX_LAST);
  assign drain_done = (state == S_BURST) && (rd_idx == IDX_LAST);
  assign gap_done   = (state == S_GAP) && (gap_cnt == GAP_END);
  assign rd_sel_n   = rd_sel ^ drain_done;

  // Fill and drain always touch different banks, so both apply together.
  always_comb begin
    full_n = full;
    if (fill_done)
      full_n[wr_sel] = 1'b1;
    if (drain_done)
      full_n[rd_sel] = 1'b0;
  end

  // Leaving BURST/GAP looks ahead so queued blocks follow with no dead cycle.
  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (full[rd_sel])
          state_n = S_BURST;
      end
      drain_done: begin
        if (GAP > 0)
          state_n = S_GAP;
        else if (full_n[rd_sel_n])
          state_n = S_BURST;
        else
          state_n = S_IDLE;
      end
      gap_done: begin
        state_n = full_n[rd_sel_n] ? S_BURST : S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      rd_sel     <= 1'b0;
      rd_idx     <= '0;
      gap_cnt    <= '0;
      full       <= '0;
      in_blk_cnt <= '0;
    end else begin
      state  <= state_n;
      rd_sel <= rd_sel_n;
      full   <= full_n;
      if (state == S_BURST)
        rd_idx <= drain_done ? '0 : rd_idx + AW'(1);
      if (state == S_GAP)
        gap_cnt <= gap_done ? '0 : gap_cnt + GW'(1);
      else
        gap_cnt <= '0;
      if (drain_done)
        in_blk_cnt <= in_blk_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_sel <= 1'b0;
      wr_idx <= '0;
    end else if (acc) begin
      wr_idx <= fill_done ? '0 : wr_idx + AW'(1);
      if (fill_done)
        wr_sel <= ~wr_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (acc)
      mem[wr_sel][wr_idx] <= s_data;
  end

  assign xin = (state == S_BURST) ? mem[rd_sel][rd_idx] : '0;

  logic [2*PW-1:0] pos;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      pos         <= '0;
      out_blk_cnt <= '0;
    end else begin
      m_valid <= core_rdy;
      m_data  <= dct_in;
      if (m_valid)
        pos <= pos + (2*PW)'(1);
      if (m_eob)
        out_blk_cnt <= out_blk_cnt + 16'd1;
    end
  end

  assign m_row = pos[2*PW-1:PW];
  assign m_col = pos[PW-1:0];
  assign m_sob = m_valid && (pos == '0);
  assign m_eob = m_valid && (&pos);

endmodule

// File: tb/tb_dct_blk_seq.sv
// Directed bench for dct_blk_seq: default, GAP=0 and N=4/GAP=2 instances
// share clock and reset; each task drives one scenario and checks inline.
module tb_dct_blk_seq;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        sv  [3];
  logic [7:0]  sd  [3];
  logic        sr  [3];
  logic [7:0]  xi  [3];
  logic        cr  [3];
  logic [11:0] di  [3];
  logic [15:0] ibc [3];
  logic [15:0] obc [3];

  logic        mv0, mv1, mv2;
  logic [11:0] md0, md1, md2;
  logic [2:0]  mr0, mc0, mr1, mc1;
  logic [1:0]  mr2, mc2;
  logic        ms0, me0, ms1, me1, ms2, me2;

  dct_blk_seq u_def (
    .CLK(CLK), .RST(RST),
    .s_valid(sv[0]), .s_data(sd[0]), .s_ready(sr[0]), .xin(xi[0]),
    .dct_in(di[0]), .core_rdy(cr[0]),
    .m_valid(mv0), .m_data(md0), .m_row(mr0), .m_col(mc0),
    .m_sob(ms0), .m_eob(me0),
    .in_blk_cnt(ibc[0]), .out_blk_cnt(obc[0])
  );

  dct_blk_seq #(.GAP(0)) u_g0 (
    .CLK(CLK), .RST(RST),
    .s_valid(sv[1]), .s_data(sd[1]), .s_ready(sr[1]), .xin(xi[1]),
    .dct_in(di[1]), .core_rdy(cr[1]),
    .m_valid(mv1), .m_data(md1), .m_row(mr1), .m_col(mc1),
    .m_sob(ms1), .m_eob(me1),
    .in_blk_cnt(ibc[1]), .out_blk_cnt(obc[1])
  );

  dct_blk_seq #(.N(4), .GAP(2)) u_n4 (
    .CLK(CLK), .RST(RST),
    .s_valid(sv[2]), .s_data(sd[2]), .s_ready(sr[2]), .xin(xi[2]),
    .dct_in(di[2]), .core_rdy(cr[2]),
    .m_valid(mv2), .m_data(md2), .m_row(mr2), .m_col(mc2),
    .m_sob(ms2), .m_eob(me2),
    .in_blk_cnt(ibc[2]), .out_blk_cnt(obc[2])
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] xq[$];
  int rv[$];
  int rl[$];

  task automatic do_reset();
    RST = 1'b0;
    for (int u = 0; u < 3; u++) begin
      sv[u] = 1'b0;
      sd[u] = '0;
      cr[u] = 1'b0;
      di[u] = '0;
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic drive(input int u, input logic [7:0] v[$], output bit stalled);
    int i;
    int budget;
    i = 0;
    budget = 0;
    stalled = 1'b0;
    while (i < v.size() && budget < 4000) begin
      @(negedge CLK);
      sv[u] = 1'b1;
      sd[u] = v[i];
      if (sr[u]) i++;
      else stalled = 1'b1;
      budget++;
    end
    @(negedge CLK);
    sv[u] = 1'b0;
    n_vec++;
    if (i !== v.size()) begin
      n_bad++;
      $display("FAIL drive%0d: accepted %0d want %0d", u, i, v.size());
    end
  endtask

  task automatic collect(input int u, input int n);
    xq.delete();
    repeat (n) begin
      @(negedge CLK);
      xq.push_back(xi[u]);
    end
  endtask

  // Run-length view of xq with the leading idle zeros dropped.
  function automatic void mk_runs();
    int k;
    rv.delete();
    rl.delete();
    k = 0;
    while (k < xq.size() && xq[k] == 8'd0) k++;
    for (; k < xq.size(); k++) begin
      if (rv.size() > 0 && rv[rv.size()-1] == int'(xq[k]))
        rl[rl.size()-1]++;
      else begin
        rv.push_back(int'(xq[k]));
        rl.push_back(1);
      end
    end
  endfunction

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 3; u++) begin
      n_vec++;
      if ({sr[u], xi[u], ibc[u], obc[u]} !== {1'b1, 8'd0, 16'd0, 16'd0}) begin
        n_bad++;
        $display("FAIL reset%0d: got %0h want %0h", u,
                 {sr[u], xi[u], ibc[u], obc[u]}, {1'b1, 40'd0});
      end
    end
    n_vec++;
    if ({mv0, md0, mr0, mc0, ms0, me0} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_out: got %0h want 0", {mv0, md0, mr0, mc0, ms0, me0});
    end
  endtask

  task automatic test_stream_gap();
    logic [7:0] v[$];
    bit st;
    int ev[4] = '{3, 0, 5, 0};
    int el[4] = '{64, 83, 64, -1};
    do_reset();
    for (int k = 0; k < 128; k++) v.push_back(k < 64 ? 8'd3 : 8'd5);
    fork
      drive(0, v, st);
      collect(0, 340);
    join
    mk_runs();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= rv.size()) begin
        n_bad++;
        $display("FAIL gap_run%0d: missing, want %0d x%0d", k, ev[k], el[k]);
      end else if (rv[k] !== ev[k] || (el[k] >= 0 && rl[k] !== el[k])) begin
        n_bad++;
        $display("FAIL gap_run%0d: got %0d x%0d want %0d x%0d",
                 k, rv[k], rl[k], ev[k], el[k]);
      end
    end
    n_vec++;
    if (ibc[0] !== 16'd2) begin
      n_bad++;
      $display("FAIL gap_inblk: got %0d want 2", ibc[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v[$];
    bit st;
    int j;
    do_reset();
    for (int k = 0; k < 192; k++) v.push_back(8'(k));
    fork
      drive(1, v, st);
      collect(1, 300);
    join
    j = -1;
    for (int k = 1; k < xq.size(); k++)
      if (j < 0 && xq[k] == 8'd1) j = k - 1;
    n_vec++;
    if (j < 0 || j + 192 >= xq.size()) begin
      n_bad++;
      $display("FAIL b2b_start: got index %0d want a burst", j);
    end else begin
      for (int k = 0; k < 192; k++) begin
        n_vec++;
        if (xq[j+k] !== 8'(k)) begin
          n_bad++;
          $display("FAIL b2b_sample%0d: got %0d want %0d", k, xq[j+k], k);
        end
      end
      n_vec++;
      if (xq[j+192] !== 8'd0) begin
        n_bad++;
        $display("FAIL b2b_tail: got %0d want 0", xq[j+192]);
      end
    end
    n_vec++;
    if (st !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_stall: got %0d want 1", st);
    end
    n_vec++;
    if (ibc[1] !== 16'd3) begin
      n_bad++;
      $display("FAIL b2b_inblk: got %0d want 3", ibc[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] v[$];
    logic [7:0] w[$];
    bit st;
    int t;
    int j;
    do_reset();
    for (int k = 0; k < 64; k++) v.push_back(8'(k + 1));
    for (int k = 0; k < 10; k++) v.push_back(8'hEE);
    drive(0, v, st);
    t = 0;
    while (xi[0] !== 8'd21 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (t >= 500) begin
      n_bad++;
      $display("FAIL mid_wait: got timeout want sample 20");
    end
    RST = 1'b0;
    #1;
    n_vec++;
    if ({xi[0], sr[0], ibc[0]} !== {8'd0, 1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: got %0h want %0h",
               {xi[0], sr[0], ibc[0]}, {8'd0, 1'b1, 16'd0});
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 64; k++) w.push_back(8'(128 + k));
    fork
      drive(0, w, st);
      collect(0, 200);
    join
    j = -1;
    for (int k = 0; k < xq.size(); k++)
      if (j < 0 && xq[k] != 8'd0) j = k;
    n_vec++;
    if (j < 0 || j + 64 >= xq.size()) begin
      n_bad++;
      $display("FAIL mid_start: got index %0d want a burst", j);
    end else begin
      for (int k = 0; k < 64; k++) begin
        n_vec++;
        if (xq[j+k] !== 8'(128 + k)) begin
          n_bad++;
          $display("FAIL mid_sample%0d: got %0d want %0d", k, xq[j+k], 128 + k);
        end
      end
      n_vec++;
      if (xq[j+64] !== 8'd0) begin
        n_bad++;
        $display("FAIL mid_tail: got %0d want 0", xq[j+64]);
      end
    end
    n_vec++;
    if (ibc[0] !== 16'd1) begin
      n_bad++;
      $display("FAIL mid_inblk: got %0d want 1", ibc[0]);
    end
  endtask

  task automatic test_output_block();
    logic [20:0] got;
    logic [20:0] exp;
    do_reset();
    for (int i = 0; i <= 64; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        got = {mv0, md0, mr0, mc0, ms0, me0};
        exp = {1'b1, 12'(i - 1), 3'((i - 1) / 8), 3'((i - 1) % 8),
               i == 1, i == 64};
        n_vec++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL out_blk%0d: got %0h want %0h", i - 1, got, exp);
        end
      end
      cr[0] = (i < 64);
      di[0] = 12'(i);
    end
    @(negedge CLK);
    n_vec++;
    if ({mv0, obc[0]} !== {1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL out_blkcnt: got %0h want %0h", {mv0, obc[0]}, {1'b0, 16'd1});
    end
  endtask

  task automatic test_output_toggle();
    logic [20:0] got;
    logic [20:0] exp;
    bit pv;
    int p;
    int eobs;
    p = 0;
    eobs = 0;
    for (int i = 0; i <= 128; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        pv = ((i - 1) % 2 == 0);
        got = {mv0, md0, mr0, mc0, ms0, me0};
        exp = {pv, 12'(i - 1), 3'(p / 8), 3'(p % 8),
               pv && p == 0, pv && p == 63};
        n_vec++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL tog%0d: got %0h want %0h", i - 1, got, exp);
        end
        if (pv) begin
          eobs += int'(me0);
          p = (p + 1) % 64;
        end
      end
      cr[0] = (i < 128) && (i % 2 == 0);
      di[0] = 12'(i);
    end
    @(negedge CLK);
    n_vec++;
    if (eobs !== 1) begin
      n_bad++;
      $display("FAIL tog_eobs: got %0d want 1", eobs);
    end
    n_vec++;
    if (obc[0] !== 16'd2) begin
      n_bad++;
      $display("FAIL tog_blkcnt: got %0d want 2", obc[0]);
    end
  endtask

  task automatic test_small_block();
    logic [7:0] v[$];
    bit st;
    logic [6:0] got;
    logic [6:0] exp;
    int ev[6] = '{1, 0, 2, 0, 3, 0};
    int el[6] = '{16, 2, 16, 2, 16, -1};
    do_reset();
    for (int k = 0; k < 48; k++) v.push_back(8'(k / 16 + 1));
    fork
      drive(2, v, st);
      collect(2, 120);
    join
    mk_runs();
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (k >= rv.size()) begin
        n_bad++;
        $display("FAIL n4_run%0d: missing, want %0d x%0d", k, ev[k], el[k]);
      end else if (rv[k] !== ev[k] || (el[k] >= 0 && rl[k] !== el[k])) begin
        n_bad++;
        $display("FAIL n4_run%0d: got %0d x%0d want %0d x%0d",
                 k, rv[k], rl[k], ev[k], el[k]);
      end
    end
    for (int i = 0; i <= 16; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        got = {mv2, mr2, mc2, ms2, me2};
        exp = {1'b1, 2'((i - 1) / 4), 2'((i - 1) % 4), i == 1, i == 16};
        n_vec++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL n4_out%0d: got %0h want %0h", i - 1, got, exp);
        end
      end
      cr[2] = (i < 16);
      di[2] = 12'(i);
    end
    @(negedge CLK);
    n_vec++;
    if ({ibc[2], obc[2]} !== {16'd3, 16'd1}) begin
      n_bad++;
      $display("FAIL n4_cnts: got %0h want %0h", {ibc[2], obc[2]}, {16'd3, 16'd1});
    end
  endtask

  initial begin
    test_reset();
    test_stream_gap();
    test_back_to_back();
    test_reset_mid_burst();
    test_output_block();
    test_output_toggle();
    test_small_block();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
